// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational 8-bit ALU among
// N_REQ valid/ready requesters, with a single registered response stage.

// Combinational 8-bit ALU: AND, OR, ADD, XOR, NOT a, SUB, SHL, SHR.
module alu_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [2:0] i_op,
  output logic [7:0] o_result,
  output logic       o_zero,
  output logic       o_carry,
  output logic       o_overflow
);
  logic [8:0] w_sum;
  logic [8:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Opcode decode; carry/overflow are only meaningful for ADD and SUB.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_result   = 8'h00;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    unique case (i_op)
      3'b000: o_result = i_a & i_b;
      3'b001: o_result = i_a | i_b;
      3'b010: begin
        o_result   = w_sum[7:0];
        o_carry    = w_sum[8];
        o_overflow = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      end
      3'b011: o_result = i_a ^ i_b;
      3'b100: o_result = ~i_a;
      3'b101: begin
        o_result   = w_diff[7:0];
        o_carry    = w_diff[8];
        o_overflow = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
      end
      3'b110: o_result = {i_a[6:0], 1'b0};
      3'b111: o_result = {1'b0, i_a[7:1]};
    endcase
  end

  assign o_zero = (o_result == 8'h00);
endmodule

module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*8-1:0]   req_a,
  input  logic [N_REQ*8-1:0]   req_b,
  input  logic [N_REQ*3-1:0]   req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 rsp_overflow,
  output logic [15:0]          grant_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_result;
  logic            r_zero;
  logic            r_carry;
  logic            r_overflow;
  logic [15:0]     r_grant_cnt;

  logic            w_any;
  logic [ID_W-1:0] w_winner;
  logic            w_can_accept;
  logic            w_accept;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [2:0]      w_op;
  logic [7:0]      w_result;
  logic            w_zero;
  logic            w_carry;
  logic            w_overflow;
  logic [ID_W-1:0] w_next_ptr;

  // Round-robin search: first valid lane at or after the pointer, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  // Accept only when the response slot is free or drains this very cycle.
  assign w_can_accept = (r_state == EMPTY) || rsp_ready;
  assign w_accept     = w_any && w_can_accept && !rst;

  // One-hot ready toward the winning lane; depends on handshake signals only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = w_accept && (w_winner == ID_W'(i));
  end

  // Operand mux feeding the shared ALU.
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_a  = req_a[i*8 +: 8];
        w_b  = req_b[i*8 +: 8];
        w_op = req_op[i*3 +: 3];
      end
    end
  end

  alu_8bit u_alu (
    .i_a       (w_a),
    .i_b       (w_b),
    .i_op      (w_op),
    .o_result  (w_result),
    .o_zero    (w_zero),
    .o_carry   (w_carry),
    .o_overflow(w_overflow)
  );

  assign w_next_ptr = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;

  // Response-stage FSM plus pointer and grant counter, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_id        <= '0;
      r_result    <= 8'h00;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_grant_cnt <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_accept) begin
        r_state    <= FULL;
        r_ptr      <= w_next_ptr;
        r_id       <= w_winner;
        r_result   <= w_result;
        r_zero     <= w_zero;
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
        if (r_grant_cnt != 16'hFFFF) r_grant_cnt <= r_grant_cnt + 16'd1;
      end else if (r_state == FULL && rsp_ready) begin
        r_state <= EMPTY;
      end
    end
  end

  assign rsp_valid    = (r_state == FULL);
  assign rsp_id       = r_id;
  assign rsp_result   = r_result;
  assign rsp_zero     = r_zero;
  assign rsp_carry    = r_carry;
  assign rsp_overflow = r_overflow;
  assign grant_cnt    = r_grant_cnt;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_overflow;
  logic [15:0] grant_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [7:0] res, input logic z, input logic c,
                           input logic o);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".id"},    32'(rsp_id),    32'(id));
    check({tag, ".res"},   32'(rsp_result), 32'(res));
    check({tag, ".zero"},  32'(rsp_zero),  32'(z));
    check({tag, ".carry"}, 32'(rsp_carry), 32'(c));
    check({tag, ".ovf"},   32'(rsp_overflow), 32'(o));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset state, with every lane requesting.
    tick();
    check_rsp("reset", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.grant", 32'(grant_cnt), 32'h0);
    check("reset.ready", 32'(req_ready), 32'h0);
    req_valid = 4'h0;
    rst = 1'b0;
    tick();

    // Lane 1: 0x7F + 0x01 -> 0x80, signed overflow.
    set_lane(1, 8'h7F, 8'h01, 3'b010);
    req_valid = 4'b0010;
    #1 check("single.ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'h0;
    check_rsp("single", 1'b1, 2'd1, 8'h80, 1'b0, 1'b0, 1'b1);
    check("single.grant", 32'(grant_cnt), 32'd1);
    // Pointer moved to 2: with all lanes valid, lane 2 wins.
    req_valid = 4'hF;
    #1 check("ptr2.ready", 32'(req_ready), 32'b0100);
    req_valid = 4'h0;
    tick();
    check("drain.valid", 32'(rsp_valid), 32'd0);
    check("drain.hold", 32'(rsp_result), 32'h80);

    // Lane 0 borrow: 0x00 - 0x01 -> 0xFF, carry=1.
    set_lane(0, 8'h00, 8'h01, 3'b101);
    req_valid = 4'b0001;
    tick();
    check_rsp("borrow", 1'b1, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Lane 0 AND 0xF0 & 0x0F -> 0x00, zero=1 (back-to-back with drain).
    set_lane(0, 8'hF0, 8'h0F, 3'b000);
    tick();
    req_valid = 4'h0;
    check_rsp("and", 1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("and.grant", 32'(grant_cnt), 32'd3);
    tick();

    // Fresh reset, then round-robin with all lanes valid: lane i adds 0x10*i + i.
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 8'(i * 16), 8'(i), 3'b010);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr.id", 32'(rsp_id), 32'(k % 4));
      check("rr.res", 32'(rsp_result), 32'((k % 4) * 8'h11));
    end
    check("rr.grant", 32'(grant_cnt), 32'd6);

    // Backpressure: FULL (id 1, 0x11), lanes 2 and 3 valid, rsp_ready low.
    req_valid = 4'b1100;
    rsp_ready = 1'b0;
    #1 check("bp.ready0", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp.ready", 32'(req_ready), 32'h0);
      check_rsp("bp", 1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 1'b0);
      check("bp.grant", 32'(grant_cnt), 32'd6);
    end
    rsp_ready = 1'b1;
    #1 check("bp.release_ready", 32'(req_ready), 32'b0100);
    tick();
    check_rsp("bp.refill", 1'b1, 2'd2, 8'h22, 1'b0, 1'b0, 1'b0);
    check("bp.grant7", 32'(grant_cnt), 32'd7);

    // Async reset mid-cycle while FULL.
    #3 rst = 1'b1;
    #1;
    check("arst.valid", 32'(rsp_valid), 32'd0);
    check("arst.grant", 32'(grant_cnt), 32'd0);
    check("arst.ready", 32'(req_ready), 32'h0);
    tick();
    check("arst.hold", 32'(rsp_valid), 32'd0);
    #3 rst = 1'b0;
    req_valid = 4'b1110;
    #1 check("arst.first_ready", 32'(req_ready), 32'b0010);
    tick();
    check_rsp("arst.first", 1'b1, 2'd1, 8'h11, 1'b0, 1'b0, 1'b0);
    check("arst.grant1", 32'(grant_cnt), 32'd1);

    // Saturation: all lanes valid, one accept per cycle.
    req_valid = 4'hF;
    for (int k = 0; k < 65533; k++) tick();
    check("sat.fffe", 32'(grant_cnt), 32'hFFFE);
    tick();
    check("sat.ffff", 32'(grant_cnt), 32'hFFFF);
    for (int k = 0; k < 5; k++) tick();
    check("sat.hold", 32'(grant_cnt), 32'hFFFF);
    check("sat.valid", 32'(rsp_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational `alu_8bit` instance among `N_REQ` requesters. Arbitration is round-robin, and each side uses a valid/ready handshake. An accepted operation is evaluated by the ALU and captured, together with the requester ID and flags, into a single registered response stage. The block sits between the per-lane operand sources and the shared arithmetic resource, so each lane gets a fair, back-pressured ALU port.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester ID. Must satisfy `$clog2(N_REQ)`, minimum 1.
- `clk` input, 1 bit: single clock, rising-edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req_valid` input, `N_REQ` bits: bit i means requester i presents an operation.
- `req_ready` output, `N_REQ` bits: bit i means requester i's operation is accepted this cycle. At most one bit is set.
- `req_a` input, `N_REQ*8` bits: operand A. Lane i is `[8i+7:8i]`.
- `req_b` input, `N_REQ*8` bits: operand B, same packing as `req_a`.
- `req_op` input, `N_REQ*3` bits: ALU opcode. Lane i is `[3i+2:3i]`. Encoding is the `alu_8bit` encoding (000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOT a, 101 SUB, 110 SHL, 111 SHR).
- `rsp_valid` output, 1 bit: the response register holds a result.
- `rsp_ready` input, 1 bit: downstream consumes the response.
- `rsp_id` output, `ID_W` bits: index of the requester that issued the result.
- `rsp_result` output, 8 bits: ALU result.
- `rsp_zero`, `rsp_carry`, `rsp_overflow` outputs, 1 bit each: ALU flags captured with the result.
- `grant_cnt` output, 16 bits: total accepted operations. Saturates at 0xFFFF.

## Operation
- Response stage FSM has two states:
  - EMPTY, where `rsp_valid`=0.
  - FULL, where `rsp_valid`=1.
- `can_accept` = EMPTY, or FULL with `rsp_ready`=1 (same-cycle drain and refill).
- Arbiter:
  - Round-robin pointer `ptr` (`ID_W` bits).
  - The winner is the first i with `req_valid[i]`=1, scanning from `ptr` upward with modulo-`N_REQ` wrap.
  - `req_ready[winner]` = `can_accept`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. It never depends on `req_a`, `req_b` or `req_op`.
- On accept (any `req_valid[i] && req_ready[i]`):
  - The winner's a, b and op are muxed into the shared ALU.
  - The ALU outputs are latched into `rsp_result` and the three flags.
  - `rsp_id` takes the winner index and the state goes to FULL.
  - `ptr` takes (winner+1) mod `N_REQ`.
  - `grant_cnt` increments unless it already equals 0xFFFF.
- FULL with `rsp_ready`=1 and no accept: go to EMPTY. Data registers hold their last values.
- FULL with `rsp_ready`=0: all response registers hold. `req_ready` is all zero.
- No request valid: `ptr` unchanged, no state change apart from draining.
- ALU semantics are exactly those of `alu_8bit`:
  - ADD carry = bit 8 of the 9-bit sum.
  - SUB carry = bit 8 of the 9-bit (a-b), which is 1 on borrow.
  - overflow is signed overflow for ADD and SUB only. carry and overflow are 0 for all other ops.
  - zero = (result == 0).
- Requesters must hold `req_valid` and their operands stable until accepted. The block does not check this.

## Timing
- Reset values:
  - `rsp_valid`=0 and `ptr`=0.
  - `rsp_id`=0, `rsp_result`=0x00.
  - `rsp_zero`=0, `rsp_carry`=0, `rsp_overflow`=0.
  - `grant_cnt`=0.
  - `req_ready`=0 while `rst` is high.
- Asserting `rst` mid-operation discards any pending response immediately, without waiting for a clock edge. A requester handshaking in that cycle is not considered accepted.
- Latency: accept at edge N means `rsp_valid`=1 and the data are visible after edge N, i.e. one cycle.
- Throughput: one operation per cycle when `rsp_ready` is held at 1.
- Simultaneous drain and accept: the new response replaces the old one at the same edge with no bubble. `rsp_valid` stays 1.
- Fairness: a continuously valid requester is granted within `N_REQ` accepts.

## Test plan
- Reset then single request: lane 1 presents a=0x7F, b=0x01, op=010, with `rsp_ready`=1.
  - One cycle later: `rsp_valid`=1, `rsp_id`=1, `rsp_result`=0x80, carry=0, overflow=1, zero=0.
  - `ptr` becomes 2.
- Borrow case: lane 0 presents a=0x00, b=0x01, op=101.
  - Response: result=0xFF, carry=1, overflow=0, zero=0.
  - AND of 0xF0 and 0x0F gives result=0x00, zero=1.
- Round-robin: all 4 lanes valid continuously, `rsp_ready`=1.
  - `rsp_id` sequence is 0,1,2,3,0,1 on consecutive cycles.
  - `grant_cnt` reaches 6.
- Backpressure: while FULL, hold `rsp_ready`=0 for 5 cycles with lanes 2 and 3 valid.
  - `req_ready`=0 and all `rsp_*` are stable.
  - On raising `rsp_ready`, the drain and a new accept happen in the same edge.
- Async reset mid-stream: assert `rst` between clock edges while FULL.
  - `rsp_valid` drops without waiting for a clock edge; `ptr`=0 and `grant_cnt`=0.
  - The first grant after release goes to the lowest valid lane.
- Counter saturation: force 65,540 accepts. `grant_cnt` holds at 0xFFFF.
